// File: rtl/game_sequencer.sv
// game_sequencer -- round scheduler for the keypad reaction game.
//
// Latches the one-hot difficulty when level_valid is seen in IDLE, then
// issues a fixed number of targets at a level-dependent period, scores hits
// and expiries, and raises game_over until reset.
//
//   level 3'b001 : speed 1,  8 targets, period BASE_PERIOD
//   level 3'b010 : speed 2, 12 targets, period BASE_PERIOD/2
//   level 3'b100 : speed 4, 16 targets, period BASE_PERIOD/4
//
// Parameters:
//   BASE_PERIOD  clk cycles per target at speed 1 (>=4, multiple of 4)
//   PERIOD_W     width of the tick counter (must hold BASE_PERIOD-1)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-low reset
//   level[2:0]   in   one-hot difficulty {hard, mid, easy}
//   level_valid  in   level is final; sampled only in IDLE
//   hit          in   one-cycle pulse, player struck the current target
//   spawn        out  one-cycle pulse, new target issued
//   target_num   out  0-based index of the most recent target
//   active       out  a target is outstanding
//   score        out  targets hit
//   miss_cnt     out  targets expired unhit (plus stray hits when penalised)
//   speed        out  latched speed multiplier 1/2/4, 0 before latch
//   busy         out  sequencer is arming or running a round
//   game_over    out  round finished, held until reset
//
// Build option:
//   GAME_SEQ_PENALTY_EN  when defined, a hit with no outstanding target
//                        during RUN increments miss_cnt (saturating at 31).

module game_sequencer #(
    parameter int unsigned BASE_PERIOD = 50_000_000,
    parameter int unsigned PERIOD_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] level,
    input  logic       level_valid,
    input  logic       hit,
    output logic       spawn,
    output logic [4:0] target_num,
    output logic       active,
    output logic [4:0] score,
    output logic [4:0] miss_cnt,
    output logic [2:0] speed,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam logic [PERIOD_W-1:0] PERIOD_X1 = PERIOD_W'(BASE_PERIOD);
    localparam logic [PERIOD_W-1:0] PERIOD_X2 = PERIOD_W'(BASE_PERIOD / 2);
    localparam logic [PERIOD_W-1:0] PERIOD_X4 = PERIOD_W'(BASE_PERIOD / 4);

    state_t              state, state_n;
    logic [2:0]          lvl_q, lvl_n;
    logic [PERIOD_W-1:0] period, period_n;
    logic [PERIOD_W-1:0] tick, tick_n;
    logic [4:0]          count, count_n;
    logic [4:0]          issued, issued_n;
    logic [4:0]          target_num_n, score_n, miss_n;
    logic [2:0]          speed_n;
    logic                spawn_n, active_n, busy_n, game_over_n;
    logic                level_ok;

    assign level_ok = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);

    always_comb begin
        state_n      = state;
        lvl_n        = lvl_q;
        period_n     = period;
        tick_n       = tick;
        count_n      = count;
        issued_n     = issued;
        target_num_n = target_num;
        score_n      = score;
        miss_n       = miss_cnt;
        speed_n      = speed;
        spawn_n      = 1'b0;
        active_n     = active;
        game_over_n  = game_over;

        unique case (state)
            IDLE: begin
                // Capture the level seen at acceptance so a change between
                // acceptance and ARM cannot select an illegal decode.
                if (level_valid && level_ok) begin
                    lvl_n   = level;
                    state_n = ARM;
                end
            end

            ARM: begin
                unique case (lvl_q)
                    3'b010: begin
                        speed_n  = 3'd2;
                        count_n  = 5'd12;
                        period_n = PERIOD_X2;
                    end
                    3'b100: begin
                        speed_n  = 3'd4;
                        count_n  = 5'd16;
                        period_n = PERIOD_X4;
                    end
                    default: begin
                        speed_n  = 3'd1;
                        count_n  = 5'd8;
                        period_n = PERIOD_X1;
                    end
                endcase
                score_n  = '0;
                miss_n   = '0;
                issued_n = '0;
                active_n = 1'b0;
                tick_n   = '0;
                state_n  = RUN;
            end

            RUN: begin
                if (hit && active) begin
                    score_n  = score + 5'd1;
                    active_n = 1'b0;
                end
`ifdef GAME_SEQ_PENALTY_EN
                else if (hit && !active && miss_cnt != 5'd31) begin
                    miss_n = miss_cnt + 5'd1;
                end
`endif

                if (tick != '0) begin
                    tick_n = tick - 1'b1;
                end else begin
                    // A hit on the expiry edge scores; only an unhit target misses.
                    if (active && !hit) begin
                        miss_n = miss_cnt + 5'd1;
                    end
                    if (issued == count) begin
                        active_n    = 1'b0;
                        game_over_n = 1'b1;
                        state_n     = DONE;
                    end else begin
                        spawn_n      = 1'b1;
                        target_num_n = issued;
                        issued_n     = issued + 5'd1;
                        active_n     = 1'b1;
                        tick_n       = period - 1'b1;
                    end
                end
            end

            DONE: begin
                // Frozen until reset.
            end

            default: state_n = IDLE;
        endcase

        busy_n = (state_n == ARM) || (state_n == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            lvl_q      <= '0;
            period     <= '0;
            tick       <= '0;
            count      <= '0;
            issued     <= '0;
            target_num <= '0;
            score      <= '0;
            miss_cnt   <= '0;
            speed      <= '0;
            spawn      <= 1'b0;
            active     <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            lvl_q      <= lvl_n;
            period     <= period_n;
            tick       <= tick_n;
            count      <= count_n;
            issued     <= issued_n;
            target_num <= target_num_n;
            score      <= score_n;
            miss_cnt   <= miss_n;
            speed      <= speed_n;
            spawn      <= spawn_n;
            active     <= active_n;
            busy       <= busy_n;
            game_over  <= game_over_n;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with BASE_PERIOD=8, giving periods
// of 8, 4 and 2 cycles for the three levels. Expected spawns are queued when
// a round is started and popped as the DUT spawns; planned hits are queued
// by edge number.

module tb_game_sequencer;

    localparam int unsigned BP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] level = 3'b000;
    logic       level_valid = 1'b0;
    logic       hit = 1'b0;
    logic       spawn;
    logic [4:0] target_num;
    logic       active;
    logic [4:0] score;
    logic [4:0] miss_cnt;
    logic [2:0] speed;
    logic       busy;
    logic       game_over;

    int vectors = 0;
    int miscompares = 0;
    int ecnt = 0;

    typedef struct {
        int num;
        int at_edge;
    } spawn_t;

    spawn_t exp_q[$];
    int     hit_q[$];

    game_sequencer #(.BASE_PERIOD(BP), .PERIOD_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .level(level),
        .level_valid(level_valid),
        .hit(hit),
        .spawn(spawn),
        .target_num(target_num),
        .active(active),
        .score(score),
        .miss_cnt(miss_cnt),
        .speed(speed),
        .busy(busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Advance one rising edge and settle; ecnt then names that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        level_valid = 1'b0;
        hit = 1'b0;
        repeat (3) step();
        vectors++;
        if ({spawn, target_num, active, score, miss_cnt, speed, busy, game_over} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {spawn, target_num, active, score, miss_cnt, speed, busy, game_over});
        end
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if (busy !== 1'b0 || spawn !== 1'b0 || speed !== 3'd0) begin
            miscompares++;
            $display("FAIL idle_no_valid: busy=%b spawn=%b speed=%0d expected 0/0/0", busy, spawn, speed);
        end
    endtask

    // mode 0: no hits; 1: hit one edge after each spawn; 2: hit on each expiry
    // edge; 3: stray hit at first spawn edge, then hit+stray on targets 0 and 1.
    task automatic test_round(input logic [2:0] lvl, input int mode, input string name);
        int     spd, cnt, per, e0, go_edge, exp_score, exp_miss;
        logic   saw_go;
        spawn_t s;
        logic [4:0] fz_score, fz_miss;

        case (lvl)
            3'b010:  begin spd = 2; cnt = 12; per = BP / 2; end
            3'b100:  begin spd = 4; cnt = 16; per = BP / 4; end
            default: begin spd = 1; cnt = 8;  per = BP;     end
        endcase
        exp_score = (mode == 0) ? 0 : (mode == 3) ? 2 : cnt;
        exp_miss  = cnt - exp_score;
`ifdef GAME_SEQ_PENALTY_EN
        if (mode == 3) exp_miss = exp_miss + 3;
`endif

        exp_q.delete();
        hit_q.delete();
        rst = 1'b1;
        hit = 1'b0;
        level = lvl;
        level_valid = 1'b1;
        e0 = ecnt + 1;
        for (int k = 0; k < cnt; k++) exp_q.push_back('{k, e0 + 2 + k * per});
        go_edge = e0 + 2 + cnt * per;
        if (mode == 3) hit_q.push_back(e0 + 2);

        saw_go = 1'b0;
        while (!saw_go && ecnt < go_edge + 4) begin
            step();
            if (hit_q.size() > 0 && hit_q[0] == ecnt) void'(hit_q.pop_front());
            if (ecnt == e0 + 1) begin
                vectors++;
                if (speed !== 3'(spd)) begin
                    miscompares++;
                    $display("FAIL %s speed_latch: got %0d expected %0d", name, speed, spd);
                end
                // Later level changes must not affect the round.
                level = (lvl == 3'b001) ? 3'b100 : 3'b001;
            end
            if (spawn) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s extra_spawn: got spawn at edge %0d expected none", name, ecnt - e0);
                end else begin
                    s = exp_q.pop_front();
                    if (target_num !== 5'(s.num) || ecnt != s.at_edge || active !== 1'b1) begin
                        miscompares++;
                        $display("FAIL %s spawn: got num=%0d edge=E0+%0d active=%b expected num=%0d edge=E0+%0d active=1",
                                 name, target_num, ecnt - e0, active, s.num, s.at_edge - e0);
                    end
                end
                if (mode == 1) hit_q.push_back(ecnt + 1);
                if (mode == 2) hit_q.push_back(ecnt + per);
                if (mode == 3 && target_num < 5'd2) begin
                    hit_q.push_back(ecnt + 1);
                    hit_q.push_back(ecnt + 2);
                end
            end
            if (game_over) begin
                saw_go = 1'b1;
                vectors++;
                if (ecnt != go_edge) begin
                    miscompares++;
                    $display("FAIL %s game_over_edge: got E0+%0d expected E0+%0d", name, ecnt - e0, go_edge - e0);
                end
            end
            hit = (hit_q.size() > 0 && hit_q[0] == ecnt + 1);
        end
        hit = 1'b0;

        vectors++;
        if (!saw_go) begin
            miscompares++;
            $display("FAIL %s timeout: got no game_over expected at E0+%0d", name, go_edge - e0);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s spawn_count: got %0d spawns expected %0d", name, cnt - exp_q.size(), cnt);
        end
        vectors++;
        if (score !== 5'(exp_score) || miss_cnt !== 5'(exp_miss)) begin
            miscompares++;
            $display("FAIL %s final_counts: got score=%0d miss=%0d expected score=%0d miss=%0d",
                     name, score, miss_cnt, exp_score, exp_miss);
        end
        vectors++;
        if (busy !== 1'b0 || active !== 1'b0 || speed !== 3'(spd) || target_num !== 5'(cnt - 1)) begin
            miscompares++;
            $display("FAIL %s done_state: got busy=%b active=%b speed=%0d tnum=%0d expected 0/0/%0d/%0d",
                     name, busy, active, speed, target_num, spd, cnt - 1);
        end

        // DONE ignores hits and level_valid.
        fz_score = 5'(exp_score);
        fz_miss  = 5'(exp_miss);
        level = lvl;
        for (int i = 0; i < 6; i++) begin
            hit = i[0];
            step();
            vectors++;
            if (game_over !== 1'b1 || spawn !== 1'b0 || score !== fz_score || miss_cnt !== fz_miss) begin
                miscompares++;
                $display("FAIL %s frozen: got go=%b spawn=%b score=%0d miss=%0d expected 1/0/%0d/%0d",
                         name, game_over, spawn, score, miss_cnt, fz_score, fz_miss);
            end
        end
        hit = 1'b0;

        rst = 1'b0;
        level_valid = 1'b0;
        step();
        vectors++;
        if ({spawn, target_num, active, score, miss_cnt, speed, busy, game_over} !== 22'd0) begin
            miscompares++;
            $display("FAIL %s reset_from_done: got %b expected all zero", name,
                     {spawn, target_num, active, score, miss_cnt, speed, busy, game_over});
        end
        rst = 1'b1;
    endtask

    task automatic test_illegal_level();
        logic [2:0] bad;
        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            bad = (j == 0) ? 3'b011 : 3'b000;
            level = bad;
            level_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                vectors++;
                if (busy !== 1'b0 || spawn !== 1'b0 || speed !== 3'd0) begin
                    miscompares++;
                    $display("FAIL illegal_%b: got busy=%b spawn=%b speed=%0d expected 0/0/0", bad, busy, spawn, speed);
                end
            end
        end
        level = 3'b001;
        step();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL legal_after_illegal_arm: got busy=%b expected 1", busy);
        end
        step();
        step();
        vectors++;
        if (spawn !== 1'b1 || target_num !== 5'd0 || speed !== 3'd1) begin
            miscompares++;
            $display("FAIL legal_after_illegal_spawn: got spawn=%b tnum=%0d speed=%0d expected 1/0/1",
                     spawn, target_num, speed);
        end
        rst = 1'b0;
        level_valid = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_abort();
        int seen, e0;
        logic got;
        rst = 1'b1;
        level = 3'b010;
        level_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 100 && seen < 5; i++) begin
            step();
            if (spawn) seen++;
        end
        vectors++;
        if (seen != 5) begin
            miscompares++;
            $display("FAIL abort_spawns: got %0d spawns expected 5", seen);
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({spawn, target_num, active, score, miss_cnt, speed, busy, game_over} !== 22'd0) begin
            miscompares++;
            $display("FAIL abort_reset: got %b expected all zero",
                     {spawn, target_num, active, score, miss_cnt, speed, busy, game_over});
        end
        rst = 1'b1;
        e0 = ecnt + 1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (spawn) begin
                got = 1'b1;
                vectors++;
                if (target_num !== 5'd0 || ecnt != e0 + 2) begin
                    miscompares++;
                    $display("FAIL rearm_first_spawn: got tnum=%0d edge=E0+%0d expected 0/E0+2",
                             target_num, ecnt - e0);
                end
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL rearm_timeout: got no spawn expected spawn at E0+2");
        end
        rst = 1'b0;
        level_valid = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_round(3'b001, 0, "easy_no_hits");
        test_round(3'b100, 1, "hard_hit_next");
        test_round(3'b010, 2, "mid_hit_expiry");
        test_illegal_level();
        test_abort();
        test_round(3'b001, 3, "easy_stray");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Round scheduler for the keypad reaction game. It sits between the level-select stage and the target/display logic: latches the chosen difficulty, issues a fixed number of targets at a level-dependent rate, scores hits and misses, and flags game over. This is the level-driven sequencing (speed ×1/×2/×4, 8/12/16 targets) left to the game manager.

## Interface
Parameters:
- BASE_PERIOD, default 50_000_000: clk cycles per target at speed ×1. Must be ≥4 and a multiple of 4.
- PERIOD_W, default 32: tick counter width. Must hold BASE_PERIOD−1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- level  in  3  one-hot difficulty {hard, mid, easy}.
- level_valid  in  1  level stable and final (level-select end flag); level-sensitive.
- hit  in  1  one-cycle pulse: player struck current target.
- spawn  out  1  one-cycle pulse: new target issued.
- target_num  out  5  index of most recent target, 0-based.
- active  out  1  a target is outstanding.
- score  out  5  targets hit.
- miss_cnt  out  5  targets expired unhit (plus stray hits, see Configuration).
- speed  out  3  latched speed multiplier: 1, 2 or 4; 0 before latch.
- busy  out  1  state is ARM or RUN.
- game_over  out  1  round finished; held until reset.

## Operation
- All outputs registered. Reset value of every output: 0. State resets to IDLE.
- Level decode: 3'b001 → speed 1, count 8, period BASE_PERIOD. 3'b010 → speed 2, count 12, period BASE_PERIOD/2. 3'b100 → speed 4, count 16, period BASE_PERIOD/4. Any other value is illegal.
- IDLE: if level_valid=1 and level legal → ARM. Illegal or level_valid=0 → stay IDLE.
- ARM (one cycle): latch speed, count and period. Clear score, miss_cnt, issued and active. Set tick=0. → RUN.
- RUN, on each edge:
  - hit=1 and active=1 → score+1, active=0.
  - tick≠0 → tick−1.
  - tick=0:
    - If active=1 and no hit this edge → miss_cnt+1.
    - Then if issued=count → DONE with active=0 and no spawn.
    - Else spawn=1, target_num=issued, issued+1, active=1, tick=period−1.
- Simultaneous hit and tick=0 with active: scored as a hit, not a miss. The next target spawns on the same edge, and active stays 1 for the new target.
- hit with active=0 is ignored (default build).
- DONE: game_over=1, busy=0, counters frozen. All inputs are ignored until rst=0.
- level and level_valid changes after ARM are ignored. The latched values rule the round.
- Counters never exceed 16. score+miss_cnt=count at DONE (default build).
- rst=0 in any state aborts the round on that edge, back to IDLE with all outputs 0.

## Timing
- Edge E0 samples level_valid=1 in IDLE. E1: ARM. E2: first spawn, high the cycle after E2.
- Spawn k (0-based) at edge E2+k·period. Spawn is exactly one cycle wide.
- Final resolution, DONE entry and game_over rise at edge E2+count·period.
- Hit window for target k: edges E2+k·period+1 through E2+(k+1)·period inclusive.
- Latency from hit pulse to score update: 1 edge.

## Configuration
- GAME_SEQ_PENALTY_EN defined: a hit with active=0 in RUN increments miss_cnt, saturating at 31. score+miss_cnt may then exceed count.
- Undefined: stray hits are ignored.
- Either build: hit outside RUN is always ignored.

## Test plan
- BASE_PERIOD=4, level=001, no hits: spawns at E2,6,10,…,30; game_over at edge 34; score=0, miss_cnt=8, speed=1.
- BASE_PERIOD=8, level=100, hit one edge after every spawn: period 2, 16 spawns; score=16, miss_cnt=0, game_over at E2+32.
- BASE_PERIOD=8, level=010: hit coincident with every tick=0 resolution edge. Each counted as a hit; final score=12, miss_cnt=0; spawn cadence unbroken at 4 cycles.
- level=011 or 000 with level_valid=1: stays IDLE, busy=0, no spawn. Then level=001 → normal round starts.
- rst=0 mid-RUN after 5 spawns: next edge all outputs 0, IDLE. Re-arm with level_valid gives a fresh round from target_num=0.
- Stray hits with active=0 (two pulses), level=001, BASE_PERIOD=4, no other hits: miss_cnt=8 by default; 10 with GAME_SEQ_PENALTY_EN.
